// File: rtl/alarm_button_pio_in.sv
// Avalon-MM input PIO: synchronises and debounces external buttons, captures qualifying
// edges into a sticky W1C register and raises a masked level interrupt.
module alarm_button_pio_in #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned EDGE_TYPE       = 1,
  parameter bit          IDLE_LEVEL      = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [WIDTH-1:0] IdleV  = {WIDTH{IDLE_LEVEL}};
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_sync1, r_sync2, r_stable;
  logic [CNT_W-1:0] r_cnt [WIDTH];
  logic [WIDTH-1:0] r_irq_mask, r_edgecap;

  logic [WIDTH-1:0] w_stable_d;
  logic [CNT_W-1:0] w_cnt_d [WIDTH];
  logic [WIDTH-1:0] w_changed, w_edge_set, w_w1c, w_edgecap_d;
  logic             w_wr;
  logic             w_unused_wdata;

  assign w_wr           = chipselect & ~write_n;
  assign w_unused_wdata = ^writedata;

  // A mismatch must persist for DEBOUNCE_CYCLES consecutive samples; any match restarts it.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      w_stable_d[i] = r_stable[i];
      w_cnt_d[i]    = r_cnt[i];
      if (r_sync2[i] == r_stable[i]) begin
        w_cnt_d[i] = '0;
      end else if (r_cnt[i] == CntMax) begin
        w_stable_d[i] = r_sync2[i];
        w_cnt_d[i]    = '0;
      end else begin
        w_cnt_d[i] = r_cnt[i] + CNT_W'(1);
      end
    end
  end

  assign w_changed = w_stable_d ^ r_stable;

  always_comb begin
    if (EDGE_TYPE == 0) begin
      w_edge_set = w_changed & w_stable_d;
    end else if (EDGE_TYPE == 1) begin
      w_edge_set = w_changed & ~w_stable_d;
    end else begin
      w_edge_set = w_changed;
    end
  end

  // A new edge on the same clock as its W1C clear keeps the bit set.
  assign w_w1c       = (w_wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
  assign w_edgecap_d = (r_edgecap & ~w_w1c) | w_edge_set;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1    <= IdleV;
      r_sync2    <= IdleV;
      r_stable   <= IdleV;
      r_irq_mask <= '0;
      r_edgecap  <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1   <= in_port;
      r_sync2   <= r_sync1;
      r_stable  <= w_stable_d;
      r_edgecap <= w_edgecap_d;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= w_cnt_d[i];
      end
      if (w_wr && address == 2'd2) begin
        r_irq_mask <= writedata[WIDTH-1:0];
      end
    end
  end

  always_comb begin
    readdata = '0;
    unique case (address)
      2'd0:    readdata = 32'(r_stable);
      2'd2:    readdata = 32'(r_irq_mask);
      2'd3:    readdata = 32'(r_edgecap);
      default: readdata = '0;
    endcase
  end

  assign irq = |(r_edgecap & r_irq_mask);

endmodule
